// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared types and helpers for the load/store unit: access
//               size and signedness encodings, LSU state, lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

   // Access size; encoding 2'd3 is reserved and treated as illegal.
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } int_size_t;

   typedef enum logic {
      UNSIGNED = 1'b0,
      SIGNED   = 1'b1
   } signedness_t;

   typedef enum logic [1:0] {
      LSU_IDLE  = 2'd0,
      LSU_BUS   = 2'd1,
      LSU_RDATA = 2'd2,
      LSU_RESP  = 2'd3
   } lsu_state_t;

   typedef bit [3:0] byte_en_t;

   // True when the access cannot be issued: misaligned or illegal size.
   function automatic logic lsu_fault(input int_size_t size, input logic [1:0] off);
      logic fault;
      case (size)
         SIZE_BYTE: fault = 1'b0;
         SIZE_HALF: fault = off[0];
         SIZE_WORD: fault = (off != 2'b00);
         default:   fault = 1'b1;
      endcase
      return fault;
   endfunction

   // Active byte lanes of the addressed word.
   function automatic byte_en_t lsu_byte_en(input int_size_t size, input logic [1:0] off);
      byte_en_t be;
      case (size)
         SIZE_BYTE: be = byte_en_t'(4'b0001 << off);
         SIZE_HALF: be = byte_en_t'(4'b0011 << off);
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate store data across lanes so the enabled lanes carry it.
   function automatic logic [31:0] lsu_wdata(input int_size_t size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SIZE_BYTE: d = {4{wdata[7:0]}};
         SIZE_HALF: d = {2{wdata[15:0]}};
         default:   d = wdata;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load data aligner; shifts the addressed lane
//               down and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0]  i_rdata,
   input  logic [1:0]   i_offset,
   input  int_size_t    i_size,
   input  signedness_t  i_signedness,
   output logic [31:0]  o_data
);

   logic [31:0] w_shifted;
   logic        w_sext;

   assign w_shifted = i_rdata >> {i_offset, 3'b000};
   assign w_sext    = (i_signedness == SIGNED);

   // Select the access width and extend from its top bit when signed.
   always_comb begin
      o_data = '0;
      case (i_size)
         SIZE_BYTE: o_data = {{24{w_sext & w_shifted[7]}},  w_shifted[7:0]};
         SIZE_HALF: o_data = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
         SIZE_WORD: o_data = w_shifted;
         default:   o_data = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store unit bridging the execute stage to a
//               32-bit memory bus with wait-request and read-data-valid.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [31:0]  req_addr,
   input  int_size_t    req_size,
   input  signedness_t  req_signedness,
   input  logic [31:0]  req_wdata,
   output logic         resp_valid,
   output logic [31:0]  resp_rdata,
   output logic         resp_error,
   output logic [31:0]  mem_addr,
   output logic [3:0]   mem_byteenable,
   output logic [31:0]  mem_wdata,
   output logic         mem_read,
   output logic         mem_write,
   input  logic         mem_waitrequest,
   input  logic         mem_readdatavalid,
   input  logic [31:0]  mem_rdata
);

   lsu_state_t   r_state;
   logic         r_write;
   logic [1:0]   r_offset;
   int_size_t    r_size;
   signedness_t  r_signedness;
   logic         r_mem_read;
   logic         r_mem_write;
   logic [31:0]  r_mem_addr;
   logic [3:0]   r_mem_be;
   logic [31:0]  r_mem_wdata;
   logic         r_resp_valid;
   logic         r_resp_error;
   logic [31:0]  r_resp_rdata;

   logic         w_accept;
   logic         w_fault;
   logic [31:0]  w_load_data;

   assign req_ready = (r_state == LSU_IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_fault   = lsu_fault(req_size, req_addr[1:0]);

   lsu_load_align u_load_align (
      .i_rdata      (mem_rdata),
      .i_offset     (r_offset),
      .i_size       (r_size),
      .i_signedness (r_signedness),
      .o_data       (w_load_data)
   );

   // Request FSM; every bus and response output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= LSU_IDLE;
         r_write      <= 1'b0;
         r_offset     <= 2'b00;
         r_size       <= SIZE_BYTE;
         r_signedness <= UNSIGNED;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_be     <= '0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_error <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         case (r_state)
            LSU_IDLE: begin
               if (w_accept) begin
                  r_write      <= req_write;
                  r_offset     <= req_addr[1:0];
                  r_size       <= req_size;
                  r_signedness <= req_signedness;
                  if (w_fault) begin
                     // Faulting access answers immediately without a bus command.
                     r_state      <= LSU_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_error <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state     <= LSU_BUS;
                     r_mem_addr  <= {req_addr[31:2], 2'b00};
                     r_mem_be    <= lsu_byte_en(req_size, req_addr[1:0]);
                     r_mem_wdata <= lsu_wdata(req_size, req_wdata);
                     r_mem_read  <= !req_write;
                     r_mem_write <= req_write;
                  end
               end
            end
            LSU_BUS: begin
               if (!mem_waitrequest) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (r_write) begin
                     r_state      <= LSU_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_error <= 1'b0;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state <= LSU_RDATA;
                  end
               end
            end
            LSU_RDATA: begin
               if (mem_readdatavalid) begin
                  r_state      <= LSU_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_error <= 1'b0;
                  r_resp_rdata <= w_load_data;
               end
            end
            LSU_RESP: begin
               r_state      <= LSU_IDLE;
               r_resp_valid <= 1'b0;
            end
            default: r_state <= LSU_IDLE;
         endcase
      end
   end

   assign mem_read       = r_mem_read;
   assign mem_write      = r_mem_write;
   assign mem_addr       = r_mem_addr;
   assign mem_byteenable = r_mem_be;
   assign mem_wdata      = r_mem_wdata;
   assign resp_valid     = r_resp_valid;
   assign resp_error     = r_resp_error;
   assign resp_rdata     = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [31:0]  req_addr;
   int_size_t    req_size;
   signedness_t  req_signedness;
   logic [31:0]  req_wdata;
   logic         resp_valid;
   logic [31:0]  resp_rdata;
   logic         resp_error;
   logic [31:0]  mem_addr;
   logic [3:0]   mem_byteenable;
   logic [31:0]  mem_wdata;
   logic         mem_read;
   logic         mem_write;
   logic         mem_waitrequest;
   logic         mem_readdatavalid;
   logic [31:0]  mem_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   // Results of the most recent run_op call.
   int          o_rd_cnt, o_wr_cnt, o_both, o_resp_cnt, o_resp_cyc, o_busy_rdy;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_err;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_size          (req_size),
      .req_signedness    (req_signedness),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .resp_error        (resp_error),
      .mem_addr          (mem_addr),
      .mem_byteenable    (mem_byteenable),
      .mem_wdata         (mem_wdata),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdatavalid (mem_readdatavalid),
      .mem_rdata         (mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request (unit must be idle) and observe 14 cycles after the
   // accept edge. Waits hold the command for n_wait cycles; the read beat
   // arrives rdv_delay cycles after the unit starts waiting for it.
   task automatic run_op(input logic wr, input logic [31:0] addr, input int_size_t size,
                         input signedness_t sgn, input logic [31:0] wdata,
                         input int n_wait, input int rdv_delay, input logic [31:0] rdata);
      o_rd_cnt = 0; o_wr_cnt = 0; o_both = 0; o_resp_cnt = 0; o_resp_cyc = 0;
      o_busy_rdy = 0; o_rdata = 'x; o_err = 1'bx; o_addr = 'x; o_wdata = 'x; o_be = 'x;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
      req_signedness = sgn; req_wdata = wdata;
      mem_waitrequest = (n_wait > 0);
      tick();
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
      for (int c = 1; c <= 14; c++) begin
         mem_waitrequest   = (c <= n_wait);
         mem_readdatavalid = (c == n_wait + 2 + rdv_delay);
         mem_rdata         = mem_readdatavalid ? rdata : 32'hDEAD_DEAD;
         if (mem_read)  o_rd_cnt++;
         if (mem_write) o_wr_cnt++;
         if (mem_read && mem_write) o_both++;
         if ((mem_read || mem_write) && c == 1) begin
            o_addr = mem_addr; o_be = mem_byteenable; o_wdata = mem_wdata;
         end
         if (o_resp_cnt == 0 && !resp_valid && req_ready) o_busy_rdy++;
         if (resp_valid) begin
            if (o_resp_cnt == 0) begin
               o_resp_cyc = c; o_rdata = resp_rdata; o_err = resp_error;
            end
            o_resp_cnt++;
         end
         tick();
      end
      mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_size = SIZE_WORD; req_signedness = UNSIGNED; req_wdata = '0;
      mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_rdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_ready",   {31'd0, req_ready},  32'd0);
      chk("rst_resp_v",  {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_e",  {31'd0, resp_error}, 32'd0);
      chk("rst_rdata",   resp_rdata,          32'd0);
      chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst_addr",    mem_addr,            32'd0);
      chk("rst_be",      {28'd0, mem_byteenable}, 32'd0);
      chk("rst_wdata",   mem_wdata,           32'd0);
      rst = 1'b0;
      tick();
      chk("idle_ready",  {31'd0, req_ready},  32'd1);

      // LB signed at 0x103
      run_op(1'b0, 32'h103, SIZE_BYTE, SIGNED, 32'h0, 0, 0, 32'h80AABBCC);
      chk("lb_addr",  o_addr,            32'h100);
      chk("lb_be",    {28'd0, o_be},     32'h8);
      chk("lb_rdata", o_rdata,           32'hFFFFFF80);
      chk("lb_cyc",   o_resp_cyc,        32'd3);
      chk("lb_rdcnt", o_rd_cnt,          32'd1);
      chk("lb_wrcnt", o_wr_cnt,          32'd0);
      chk("lb_err",   {31'd0, o_err},    32'd0);
      chk("lb_rcnt",  o_resp_cnt,        32'd1);
      chk("lb_busy",  o_busy_rdy,        32'd0);
      chk("lb_ready", {31'd0, req_ready}, 32'd1);

      // LHU at 0x202
      run_op(1'b0, 32'h202, SIZE_HALF, UNSIGNED, 32'h0, 0, 0, 32'hBEEF1234);
      chk("lhu_be",    {28'd0, o_be}, 32'hC);
      chk("lhu_rdata", o_rdata,       32'h0000BEEF);
      chk("lhu_cyc",   o_resp_cyc,    32'd3);

      // LH signed at 0x000
      run_op(1'b0, 32'h000, SIZE_HALF, SIGNED, 32'h0, 0, 0, 32'h12348001);
      chk("lh_be",    {28'd0, o_be}, 32'h3);
      chk("lh_rdata", o_rdata,       32'hFFFF8001);

      // Misaligned LW at 0x006
      run_op(1'b0, 32'h006, SIZE_WORD, UNSIGNED, 32'h0, 0, 0, 32'h11111111);
      chk("lwmis_err",   {31'd0, o_err}, 32'd1);
      chk("lwmis_cyc",   o_resp_cyc,     32'd1);
      chk("lwmis_rd",    o_rd_cnt,       32'd0);
      chk("lwmis_rdata", o_rdata,        32'd0);

      // Misaligned SH at 0x003
      run_op(1'b1, 32'h003, SIZE_HALF, UNSIGNED, 32'hAAAA, 0, 0, 32'h0);
      chk("shmis_err", {31'd0, o_err}, 32'd1);
      chk("shmis_cyc", o_resp_cyc,     32'd1);
      chk("shmis_wr",  o_wr_cnt,       32'd0);

      // Illegal size
      run_op(1'b0, 32'h000, int_size_t'(2'd3), UNSIGNED, 32'h0, 0, 0, 32'h0);
      chk("sz3_err", {31'd0, o_err}, 32'd1);
      chk("sz3_cyc", o_resp_cyc,     32'd1);
      chk("sz3_rd",  o_rd_cnt,       32'd0);

      // LB unsigned to leave nonzero resp_rdata before the store
      run_op(1'b0, 32'h041, SIZE_BYTE, UNSIGNED, 32'h0, 0, 0, 32'h0000F000);
      chk("lbu_rdata", o_rdata, 32'h000000F0);

      // SB 0x5A at 0x001 with three wait cycles
      run_op(1'b1, 32'h001, SIZE_BYTE, UNSIGNED, 32'h0000005A, 3, 0, 32'h0);
      chk("sb_wdata", o_wdata,        32'h5A5A5A5A);
      chk("sb_be",    {28'd0, o_be},  32'h2);
      chk("sb_wrcnt", o_wr_cnt,       32'd4);
      chk("sb_rdcnt", o_rd_cnt,       32'd0);
      chk("sb_cyc",   o_resp_cyc,     32'd5);
      chk("sb_rdata", o_rdata,        32'd0);
      chk("sb_err",   {31'd0, o_err}, 32'd0);
      chk("sb_busy",  o_busy_rdy,     32'd0);

      // SW, no waits
      run_op(1'b1, 32'h020, SIZE_WORD, UNSIGNED, 32'hCAFEF00D, 0, 0, 32'h0);
      chk("sw_wdata", o_wdata,       32'hCAFEF00D);
      chk("sw_be",    {28'd0, o_be}, 32'hF);
      chk("sw_cyc",   o_resp_cyc,    32'd2);
      chk("sw_both",  o_both,        32'd0);

      // SH at 0x002
      run_op(1'b1, 32'h002, SIZE_HALF, UNSIGNED, 32'hABCD1234, 0, 0, 32'h0);
      chk("sh_wdata", o_wdata,       32'h12341234);
      chk("sh_be",    {28'd0, o_be}, 32'hC);

      // Stray read beat while idle
      mem_readdatavalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_readdatavalid = 1'b0;
      chk("stray_rv",    {31'd0, resp_valid}, 32'd0);
      chk("stray_ready", {31'd0, req_ready},  32'd1);
      tick();
      chk("stray_rv2",   {31'd0, resp_valid}, 32'd0);

      // LW with read data delayed five cycles
      run_op(1'b0, 32'h010, SIZE_WORD, UNSIGNED, 32'h0, 0, 5, 32'h12345678);
      chk("lwd_rdata", o_rdata,    32'h12345678);
      chk("lwd_cyc",   o_resp_cyc, 32'd8);
      chk("lwd_rcnt",  o_resp_cnt, 32'd1);
      chk("lwd_busy",  o_busy_rdy, 32'd0);

      // Reset while the bus command is stalled
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; req_size = SIZE_WORD;
      mem_waitrequest = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rbus_rd", {31'd0, mem_read}, 32'd1);
      tick();
      rst = 1'b1;
      tick();
      chk("rbus_strobe", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rbus_rv",     {31'd0, resp_valid},          32'd0);
      rst = 1'b0; mem_waitrequest = 1'b0;
      mem_readdatavalid = 1'b1; mem_rdata = 32'h55555555;
      tick();
      mem_readdatavalid = 1'b0;
      chk("rbus_ready",  {31'd0, req_ready},  32'd1);
      chk("rbus_rv2",    {31'd0, resp_valid}, 32'd0);
      tick();
      chk("rbus_rv3",    {31'd0, resp_valid}, 32'd0);
      chk("rbus_ready2", {31'd0, req_ready},  32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's execute stage and the 32-bit data memory bus. It accepts one load or store per handshake, checks alignment, and generates word-aligned bus addresses, byte enables and replicated write data. For loads it extracts and sign/zero-extends the addressed byte, half or word. It serves the datapath when `dest_reg_from` selects memory and for `OP_LOAD`/`OP_STORE` instructions.

## Interface
Parameters:
- none; all widths fixed at 32 bits (`uint32_t`).

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  unit can accept; high only in IDLE and while `rst`=0
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_size`  in  `int_size_t`  byte/half/word; encoding 2'd3 is illegal
- `req_signedness`  in  `signedness_t`  load extension mode; ignored for stores
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse, no backpressure
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_error`  out  1  misaligned or illegal size; valid with `resp_valid`
- `mem_addr`  out  32  `{addr[31:2],2'b00}`
- `mem_byteenable`  out  4  active lanes
- `mem_wdata`  out  32  lane-replicated store data
- `mem_read` / `mem_write`  out  1 each  command strobes, never both high
- `mem_waitrequest`  in  1  command not accepted this cycle
- `mem_readdatavalid`  in  1  `mem_rdata` valid
- `mem_rdata`  in  32  read word

## Operation
- Request is accepted on an edge with `req_valid && req_ready`. Address, size, signedness, write flag and wdata are registered at that edge.
- Error check at accept:
  - half with `addr[0]`=1 is an error;
  - word with `addr[1:0]`≠0 is an error;
  - size 2'd3 is an error.
  - Error → go to RESP with `resp_error`=1; no bus command is issued.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: unchanged
- Load extract:
  - shift `mem_rdata` right by `8*addr[1:0]`, then take bits [7:0], [15:0] or [31:0];
  - SIGNED sign-extends from bit 7 or 15; UNSIGNED zero-fills.
- FSM states and transitions:
  - IDLE → BUS on an aligned accept.
  - IDLE → RESP on a faulting accept.
  - BUS holds `mem_read`/`mem_write` and all `mem_*` outputs stable until a cycle with `mem_waitrequest`=0. That cycle is the last one with the strobe high.
  - BUS → RESP after a store is accepted by the bus.
  - BUS → RDATA after a load is accepted by the bus.
  - RDATA waits for `mem_readdatavalid`, latches extended data into `resp_rdata`, then → RESP.
  - RESP pulses `resp_valid` for one cycle, then → IDLE.
- `mem_readdatavalid` is ignored outside RDATA.
- `resp_rdata` and `resp_error` are held until the next RESP.

## Timing
- Reset values:
  - state IDLE;
  - `mem_read`, `mem_write`, `resp_valid`, `resp_error` = 0;
  - `mem_addr`, `mem_byteenable`, `mem_wdata`, `resp_rdata` = 0.
- Reset mid-operation returns to IDLE at the same edge and drops the strobes. A late `mem_readdatavalid` after reset is ignored.
- Accept at edge 0 gives these minimum latencies:
  - store: strobe in cycle 1, `resp_valid` in cycle 2;
  - load: strobe in cycle 1, data in cycle 2 or later, `resp_valid` in the cycle after data;
  - fault: `resp_valid` in cycle 1.
- Each wait-request cycle adds one cycle of latency, as does each readdatavalid delay cycle.
- `req_ready` is 0 from the accept edge until the unit returns to IDLE. A new request can be accepted in the cycle after `resp_valid`.

## Structure
- Add to the shared types package:
  - `lsu_state_t` enum {LSU_IDLE, LSU_BUS, LSU_RDATA, LSU_RESP};
  - `byte_en_t` as `bit [3:0]`.
- Reuse `int_size_t` and `signedness_t` unchanged.
- One combinational sub-module, `lsu_load_align`, takes rdata, offset, size and signedness and outputs the extended word.

## Test plan
- LB SIGNED at addr 0x103, `mem_rdata`=0x80AABBCC, no waits → `mem_addr`=0x100, byteenable 4'b1000, `resp_rdata`=0xFFFFFF80, `resp_valid` in cycle 3.
- LHU at 0x202, `mem_rdata`=0xBEEF1234 → byteenable 4'b1100, `resp_rdata`=0x0000BEEF.
- SB 0x5A at 0x001 with `mem_waitrequest` high 3 cycles → `mem_wdata`=0x5A5A5A5A, byteenable 4'b0010, `mem_write` high 4 cycles, `resp_valid` 1 cycle later, `resp_rdata`=0.
- LW at 0x006 → `resp_error`=1 in cycle 1, `mem_read` never asserted. Repeat with SH at 0x3 and with size 2'd3.
- LW with readdatavalid delayed 5 cycles; a stray readdatavalid while in IDLE → response only from the in-state beat, and the stray beat has no effect.
- Assert `rst` during BUS → next cycle strobes 0, `req_ready`=1 after reset deasserts, and no `resp_valid` is produced.
